data_rw_mem_stb: RTL and testbench

- Parametrised next-generation memory-access (MA) stage for the RV32I pipeline.
- Decodes each load/store as either a QSPI memory access or an IO access (address tag region).
- Memory stores are posted into a STB_DEPTH-entry store buffer, so they retire without waiting for write_finish.
- Loads drain the buffer first, then perform byte-lane extraction and sign/zero extension; results go to register-file writeback (RFW).

---
 rtl/data_rw_mem_stb.sv | 223 ++++++++++++++++++++++
 tb/tb_data_rw_mem_stb.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_rw_mem_stb.sv
// RV32I memory-access stage: posted store buffer in front of QSPI, direct IO path, load extension.
// Optional macro DMRW_MISALIGN_EN: trap misaligned accesses instead of force-aligning them.
module data_rw_mem_stb #(
  parameter int unsigned STB_DEPTH = 4,
  parameter logic [1:0]  IO_TAG    = 2'b11,
  parameter int unsigned IO_RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_ld_ma,
  input  logic        cmd_st_ma,
  input  logic        wbk_rd_reg_ma,
  input  logic [4:0]  rd_adr_ma,
  input  logic [31:0] rd_data_ma,
  input  logic [31:0] st_data_ma,
  input  logic [2:0]  ldst_code_ma,
  input  logic        cpu_stat_dmrw,
  output logic        dmrw_run,
  output logic [4:0]  rd_adr_wb,
  output logic        wbk_rd_reg_wb,
  output logic [31:0] wbk_data_wb,
  output logic        misalign_err,
  output logic        d_read_req,
  output logic [31:0] d_read_adr,
  input  logic        read_valid,
  input  logic [31:0] read_data,
  output logic        d_write_req,
  output logic [31:0] d_write_adr,
  output logic [3:0]  d_write_be,
  output logic [31:0] d_write_data,
  input  logic        write_finish,
  output logic        dma_io_we,
  output logic [13:0] dma_io_wadr,
  output logic [31:0] dma_io_wdata,
  output logic        dma_io_radr_en,
  output logic [13:0] dma_io_radr,
  input  logic [31:0] dma_io_rdata
);
  localparam int unsigned PW = (STB_DEPTH > 1) ? $clog2(STB_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {IDLE, DRAIN, READ, IORD, DONE} state_t;

  state_t        state_q;
  logic [4:0]    rd_adr_q;
  logic [31:0]   adr_q;
  logic [2:0]    code_q;
  logic [31:0]   data_q;
  logic [2:0]    lat_q;
  logic          radr_en_q, io_we_q, misalign_q;
  logic [13:0]   io_wadr_q;
  logic [31:0]   io_wdata_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic [29:0]   stb_adr  [STB_DEPTH];
  logic [3:0]    stb_be   [STB_DEPTH];
  logic [31:0]   stb_data [STB_DEPTH];

  logic        is_byte, is_half, is_word, is_io, misaligned, idle, req_ok;
  logic        mem_st, io_st, mem_ld, io_ld, mis_hit, nonmem;
  logic        full, empty, push, pop, stall;
  logic [31:0] adr, st_lane;
  logic [3:0]  st_be;

  assign is_byte = (ldst_code_ma[1:0] == 2'b00);
  assign is_half = (ldst_code_ma[1:0] == 2'b01);
  assign is_word = !is_byte && !is_half;
  assign is_io   = (rd_data_ma[31:30] == IO_TAG);

`ifdef DMRW_MISALIGN_EN
  assign misaligned = (is_half && rd_data_ma[0]) || (is_word && (rd_data_ma[1:0] != 2'b00))
                    || (is_io && !is_word);
  assign adr        = rd_data_ma;
`else
  assign misaligned = 1'b0;
  always_comb begin
    adr = rd_data_ma;
    if (is_half) adr[0] = 1'b0;
    else if (is_word) adr[1:0] = 2'b00;
  end
`endif

  assign idle    = (state_q == IDLE);
  assign req_ok  = idle && cpu_stat_dmrw && !misaligned;
  assign mem_ld  = req_ok && cmd_ld_ma && !is_io;
  assign io_ld   = req_ok && cmd_ld_ma && is_io;
  assign mem_st  = req_ok && cmd_st_ma && !cmd_ld_ma && !is_io;
  assign io_st   = req_ok && cmd_st_ma && !cmd_ld_ma && is_io;
  assign mis_hit = idle && cpu_stat_dmrw && (cmd_ld_ma || cmd_st_ma) && misaligned;
  assign nonmem  = idle && cpu_stat_dmrw && wbk_rd_reg_ma && !cmd_ld_ma && !cmd_st_ma;

  // Full is judged on the registered count only, so a stalled store pushes the cycle after a pop.
  assign full  = (count_q == CW'(STB_DEPTH));
  assign empty = (count_q == '0);
  assign push  = mem_st && !full;
  assign stall = mem_st && full;
  assign pop   = write_finish && !empty;

  always_comb begin
    st_be   = 4'b1111;
    st_lane = st_data_ma;
    if (is_byte) begin
      st_be   = 4'b0001 << adr[1:0];
      st_lane = {4{st_data_ma[7:0]}};
    end else if (is_half) begin
      st_be   = adr[1] ? 4'b1100 : 4'b0011;
      st_lane = {2{st_data_ma[15:0]}};
    end
  end

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] ofs,
                                         input logic [2:0] code);
    logic [31:0] s;
    logic [31:0] r;
    s = w >> {ofs, 3'b000};
    case (code[1:0])
      2'b00:   r = {{24{s[7] & ~code[2]}}, s[7:0]};
      2'b01:   r = {{16{s[15] & ~code[2]}}, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      stb_adr[wr_ptr_q]  <= adr[31:2];
      stb_be[wr_ptr_q]   <= st_be;
      stb_data[wr_ptr_q] <= st_lane;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_adr_q   <= '0;
      adr_q      <= '0;
      code_q     <= '0;
      data_q     <= '0;
      lat_q      <= '0;
      radr_en_q  <= 1'b0;
      io_we_q    <= 1'b0;
      io_wadr_q  <= '0;
      io_wdata_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      radr_en_q  <= 1'b0;
      io_we_q    <= 1'b0;
      misalign_q <= mis_hit;
      if (io_st) begin
        io_we_q    <= 1'b1;
        io_wadr_q  <= adr[15:2];
        io_wdata_q <= st_data_ma;
      end
      case (state_q)
        IDLE: if (mem_ld || io_ld) begin
          rd_adr_q <= rd_adr_ma;
          adr_q    <= adr;
          code_q   <= ldst_code_ma;
          if (io_ld) begin
            radr_en_q <= 1'b1;
            lat_q     <= '0;
            state_q   <= IORD;
          end else begin
            state_q <= empty ? READ : DRAIN;
          end
        end
        DRAIN: if (empty) state_q <= READ;
        READ: if (read_valid) begin
          data_q  <= extend(read_data, adr_q[1:0], code_q);
          state_q <= DONE;
        end
        // lat_q counts from the strobe cycle; data is valid IO_RD_LAT cycles after it.
        IORD: if (lat_q == 3'(IO_RD_LAT)) begin
          data_q  <= extend(dma_io_rdata, adr_q[1:0], code_q);
          state_q <= DONE;
        end else begin
          lat_q <= lat_q + 3'd1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmrw_run       = !idle || mem_ld || io_ld || stall;
  assign rd_adr_wb      = idle ? ((nonmem || mem_ld || io_ld) ? rd_adr_ma : 5'd0) : rd_adr_q;
  assign wbk_rd_reg_wb  = (state_q == DONE) || nonmem;
  assign wbk_data_wb    = (state_q == DONE) ? data_q : (nonmem ? rd_data_ma : 32'd0);
  assign misalign_err   = misalign_q;
  assign d_read_req     = (state_q == READ);
  assign d_read_adr     = {adr_q[31:2], 2'b00};
  assign d_write_req    = !empty;
  assign d_write_adr    = empty ? 32'd0 : {stb_adr[rd_ptr_q], 2'b00};
  assign d_write_be     = empty ? 4'd0 : stb_be[rd_ptr_q];
  assign d_write_data   = empty ? 32'd0 : stb_data[rd_ptr_q];
  assign dma_io_we      = io_we_q;
  assign dma_io_wadr    = io_wadr_q;
  assign dma_io_wdata   = io_wdata_q;
  assign dma_io_radr_en = radr_en_q;
  assign dma_io_radr    = adr_q[15:2];
endmodule

// File: tb/tb_data_rw_mem_stb.sv
// Directed bench for data_rw_mem_stb with a queue model of posted QSPI writes checked every cycle.
module tb_data_rw_mem_stb;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma, cpu_stat_dmrw;
  logic [4:0]  rd_adr_ma;
  logic [31:0] rd_data_ma, st_data_ma;
  logic [2:0]  ldst_code_ma;
  logic        dmrw_run, wbk_rd_reg_wb, misalign_err, d_read_req, read_valid;
  logic [4:0]  rd_adr_wb;
  logic [31:0] wbk_data_wb, d_read_adr, read_data, d_write_adr, d_write_data;
  logic        d_write_req, write_finish, dma_io_we, dma_io_radr_en;
  logic [3:0]  d_write_be;
  logic [13:0] dma_io_wadr, dma_io_radr;
  logic [31:0] dma_io_wdata, dma_io_rdata;

  data_rw_mem_stb #(.STB_DEPTH(DEPTH), .IO_TAG(2'b11), .IO_RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma),
    .wbk_rd_reg_ma(wbk_rd_reg_ma), .rd_adr_ma(rd_adr_ma), .rd_data_ma(rd_data_ma),
    .st_data_ma(st_data_ma), .ldst_code_ma(ldst_code_ma), .cpu_stat_dmrw(cpu_stat_dmrw),
    .dmrw_run(dmrw_run), .rd_adr_wb(rd_adr_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb),
    .wbk_data_wb(wbk_data_wb), .misalign_err(misalign_err), .d_read_req(d_read_req),
    .d_read_adr(d_read_adr), .read_valid(read_valid), .read_data(read_data),
    .d_write_req(d_write_req), .d_write_adr(d_write_adr), .d_write_be(d_write_be),
    .d_write_data(d_write_data), .write_finish(write_finish), .dma_io_we(dma_io_we),
    .dma_io_wadr(dma_io_wadr), .dma_io_wdata(dma_io_wdata), .dma_io_radr_en(dma_io_radr_en),
    .dma_io_radr(dma_io_radr), .dma_io_rdata(dma_io_rdata)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory-side responders ----------------
  logic [31:0] rd_word = 32'd0;
  logic [31:0] io_word = 32'd0;
  logic [3:0]  io_pipe;
  int wf_delay = 0, wf_cnt = 0, rv_cnt = 0, wf_force_n = 0, wf_force_done = 0;
  bit wf_hold = 1'b0;

  assign read_data    = read_valid ? rd_word : 32'h5A5A5A5A;
  assign dma_io_rdata = io_pipe[LAT-1] ? io_word : 32'h0BADF00D;

  always @(posedge clk) io_pipe <= rst ? 4'd0 : {io_pipe[2:0], dma_io_radr_en};

  initial begin
    write_finish = 1'b0;
    read_valid   = 1'b0;
    forever begin
      @(posedge clk); #2;
      write_finish = 1'b0;
      read_valid   = 1'b0;
      if (rst) begin
        wf_cnt = 0;
        rv_cnt = 0;
      end else begin
        if (d_write_req && (wf_force_n > wf_force_done || (!wf_hold && wf_cnt >= wf_delay))) begin
          write_finish = 1'b1;
          wf_cnt = 0;
          if (wf_force_n > wf_force_done) wf_force_done++;
        end else if (d_write_req) begin
          wf_cnt++;
        end
        if (d_read_req) begin
          if (rv_cnt >= 2) begin read_valid = 1'b1; rv_cnt = 0; end
          else rv_cnt++;
        end else begin
          rv_cnt = 0;
        end
      end
    end
  end

  // ---------------- store-buffer model: FIFO of expected QSPI writes ----------------
  typedef struct packed {logic [31:0] adr; logic [3:0] be; logic [31:0] data;} wr_t;
  wr_t wq[$];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic wr_t mk_entry(input logic [31:0] a_in, input logic [31:0] d, input logic [1:0] sz);
    wr_t e;
    int nb, off;
    logic [31:0] a;
    nb  = nbytes(sz);
    a   = a_in - (a_in % nb);
    off = int'(a % 4);
    e.adr = a - off;
    for (int i = 0; i < 4; i++) begin
      e.be[i] = (i >= off) && (i < off + nb);
      e.data[8*i +: 8] = d[8*(i % nb) +: 8];
    end
    return e;
  endfunction

  function automatic bit is_misaligned(input logic [31:0] a, input logic [1:0] sz);
    int nb;
    nb = nbytes(sz);
`ifdef DMRW_MISALIGN_EN
    return ((a % nb) != 0) || (a[31:30] == 2'b11 && nb != 4);
`else
    return (nb == 0);
`endif
  endfunction

  function automatic logic [31:0] ld_expect(input logic [31:0] w, input logic [31:0] a, input logic [2:0] code);
    int nb;
    logic [31:0] v, mask;
    nb   = nbytes(code[1:0]);
    v    = w >> (8 * (a % 4));
    mask = (nb == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v    = v & mask;
    if (!code[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  always @(posedge clk) begin
    bit do_push;
    if (rst) begin
      wq.delete();
    end else begin
      do_push = cmd_st_ma && !cmd_ld_ma && cpu_stat_dmrw && rd_data_ma[31:30] != 2'b11
             && !is_misaligned(rd_data_ma, ldst_code_ma[1:0]) && wq.size() < DEPTH;
      if (write_finish && wq.size() > 0) void'(wq.pop_front());
      if (do_push) wq.push_back(mk_entry(rd_data_ma, st_data_ma, ldst_code_ma[1:0]));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("wr_req", d_write_req, wq.size() != 0);
      if (wq.size() != 0) begin
        chk("wr_adr", d_write_adr, wq[0].adr);
        chk("wr_be", d_write_be, wq[0].be);
        chk("wr_data", d_write_data, wq[0].data);
      end
      chk("rd_after_drain", d_read_req && wq.size() != 0, 0);
`ifndef DMRW_MISALIGN_EN
      chk("misalign_tied", misalign_err, 0);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic ld, input logic st, input logic wbk, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] code);
    @(posedge clk); #1;
    cmd_ld_ma = ld; cmd_st_ma = st; wbk_rd_reg_ma = wbk; rd_adr_ma = rd;
    rd_data_ma = a; st_data_ma = d; ldst_code_ma = code; cpu_stat_dmrw = 1'b1;
    #2;
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    cmd_ld_ma = 1'b0; cmd_st_ma = 1'b0; wbk_rd_reg_ma = 1'b0; rd_adr_ma = 5'd0;
    rd_data_ma = 32'd0; st_data_ma = 32'd0; ldst_code_ma = 3'd0; cpu_stat_dmrw = 1'b0;
    #2;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] code,
                          input logic exp_run);
    drive(1'b0, 1'b1, 1'b0, 5'd0, a, d, code);
    chk("st_run", dmrw_run, exp_run);
    $display("store adr=%h data=%h code=%b run=%b", a, d, code, dmrw_run);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      if (!d_write_req) break;
      idle_in();
    end
    chk("drain_done", d_write_req, 0);
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [31:0] a, input logic [2:0] code,
                         input logic [31:0] word, output logic [31:0] got, output int lat,
                         output logic [31:0] adr_seen);
    rd_word = word;
    io_word = word;
    adr_seen = 32'hFFFFFFFF;
    drive(1'b1, 1'b0, 1'b0, rd, a, 32'd0, code);
    chk("ld_accept_run", dmrw_run, 1);
    chk("ld_accept_rd", rd_adr_wb, rd);
    lat = 0;
    for (int k = 0; k < 200; k++) begin
      idle_in();
      lat++;
      if (d_read_req) adr_seen = d_read_adr;
      if (dma_io_radr_en) adr_seen = {18'd0, dma_io_radr};
      if (wbk_rd_reg_wb) break;
    end
    chk("ld_wbk_seen", wbk_rd_reg_wb, 1);
    chk("ld_wbk_rd", rd_adr_wb, rd);
    chk("ld_done_run", dmrw_run, 1);
    got = wbk_data_wb;
    idle_in();
    chk("ld_wbk_pulse", wbk_rd_reg_wb, 0);
    chk("ld_idle_run", dmrw_run, 0);
    $display("load rd=%0d adr=%h code=%b word=%h -> wbk=%h after %0d cycles", rd, a, code, word, got, lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {logic [31:0] a; logic [2:0] code; logic [31:0] w;} ldvec_t;
  ldvec_t lv[5];

  initial begin
    logic [31:0] got, seen;
    int lat;

    rst = 1'b1;
    cmd_ld_ma = 1'b0; cmd_st_ma = 1'b0; wbk_rd_reg_ma = 1'b0; rd_adr_ma = 5'd0;
    rd_data_ma = 32'd0; st_data_ma = 32'd0; ldst_code_ma = 3'd0; cpu_stat_dmrw = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("rst_run", dmrw_run, 0);
    chk("rst_wbk", wbk_rd_reg_wb, 0);
    chk("rst_wbk_data", wbk_data_wb, 0);
    chk("rst_misalign", misalign_err, 0);
    chk("rst_rd_req", d_read_req, 0);
    chk("rst_rd_adr", d_read_adr, 0);
    chk("rst_wr_req", d_write_req, 0);
    chk("rst_wr_adr", d_write_adr, 0);
    chk("rst_io_we", dma_io_we, 0);
    chk("rst_io_re", dma_io_radr_en, 0);
    $display("reset checked");

    // non-memory writeback passes through in the same cycle
    drive(1'b0, 1'b0, 1'b1, 5'd5, 32'hCAFEF00D, 32'd0, 3'd0);
    chk("nm_wbk", wbk_rd_reg_wb, 1);
    chk("nm_data", wbk_data_wb, 32'hCAFEF00D);
    chk("nm_rd", rd_adr_wb, 5);
    chk("nm_run", dmrw_run, 0);
    idle_in();
    chk("nm_pulse", wbk_rd_reg_wb, 0);
    $display("nonmem rd=5 data=cafef00d");

    // posted word store, slow write_finish
    wf_delay = 5;
    do_store(32'h100, 32'h12345678, 3'b010, 1'b0);
    idle_in();
    chk("sw_req", d_write_req, 1);
    chk("sw_adr", d_write_adr, 32'h100);
    chk("sw_be", d_write_be, 4'b1111);
    chk("sw_data", d_write_data, 32'h12345678);
    wait_drain();

    do_store(32'h102, 32'h0000005A, 3'b000, 1'b0);
    idle_in();
    chk("sb_be", d_write_be, 4'b0100);
    chk("sb_data", d_write_data, 32'h5A5A5A5A);
    wait_drain();
    do_store(32'h106, 32'h00001234, 3'b001, 1'b0);
    idle_in();
    chk("sh_adr", d_write_adr, 32'h104);
    chk("sh_be", d_write_be, 4'b1100);
    chk("sh_data", d_write_data, 32'h12341234);
    wait_drain();

    // five byte stores into a four-entry buffer
    wf_hold = 1'b1;
    for (int i = 0; i < 4; i++) do_store(32'h300 + i, 32'h11 * (i + 1), 3'b000, 1'b0);
    do_store(32'h304, 32'h55, 3'b000, 1'b1);
    wf_force_n++;
    do_store(32'h304, 32'h55, 3'b000, 1'b1);
    do_store(32'h304, 32'h55, 3'b000, 1'b0);
    chk("full_head_be", d_write_be, 4'b0010);
    chk("full_head_data", d_write_data, 32'h22222222);
    idle_in();
    wf_hold = 1'b0;
    wf_delay = 0;
    wait_drain();

    // load behind two buffered stores
    wf_delay = 3;
    do_store(32'h400, 32'h0000000A, 3'b010, 1'b0);
    do_store(32'h404, 32'h0000000B, 3'b010, 1'b0);
    do_load(5'd7, 32'h203, 3'b100, 32'hAB000000, got, lat, seen);
    chk("lbu_data", got, 32'h000000AB);
    chk("lbu_rd_adr", seen, 32'h200);

    do_load(5'd8, 32'h202, 3'b001, 32'h80010000, got, lat, seen);
    chk("lh_data", got, 32'hFFFF8001);

    lv[0] = '{32'h201, 3'b000, 32'h0000FF00};
    lv[1] = '{32'h202, 3'b101, 32'h80010000};
    lv[2] = '{32'h204, 3'b010, 32'hDEADBEEF};
    lv[3] = '{32'h200, 3'b100, 32'h000000F0};
    lv[4] = '{32'h202, 3'b000, 32'h007F0000};
    for (int i = 0; i < 5; i++) begin
      do_load(5'(10 + i), lv[i].a, lv[i].code, lv[i].w, got, lat, seen);
      chk("ld_model", got, ld_expect(lv[i].w, lv[i].a, lv[i].code));
    end

    // IO load with two-cycle read latency
    do_load(5'd9, 32'hC0000010, 3'b010, 32'h13579BDF, got, lat, seen);
    chk("io_ld_data", got, 32'h13579BDF);
    chk("io_ld_radr", seen, 32'h4);
    chk("io_ld_lat", lat, 4);

    // IO store bypasses the buffer
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'hC0000020, 32'hFEEDBEEF, 3'b010);
    chk("io_st_run", dmrw_run, 0);
    idle_in();
    chk("io_we", dma_io_we, 1);
    chk("io_wadr", dma_io_wadr, 14'h0008);
    chk("io_wdata", dma_io_wdata, 32'hFEEDBEEF);
    chk("io_no_qspi", d_write_req, 0);
    idle_in();
    chk("io_we_pulse", dma_io_we, 0);
    $display("io store adr=c0000020 data=feedbeef");

    // misaligned half store
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h101, 32'h0000BEEF, 3'b001);
    chk("mis_run", dmrw_run, 0);
    idle_in();
`ifdef DMRW_MISALIGN_EN
    chk("mis_err", misalign_err, 1);
    chk("mis_no_req", d_write_req, 0);
    idle_in();
    chk("mis_pulse", misalign_err, 0);
`else
    chk("fa_req", d_write_req, 1);
    chk("fa_adr", d_write_adr, 32'h100);
    chk("fa_be", d_write_be, 4'b0011);
    chk("fa_data", d_write_data, 32'hBEEFBEEF);
`endif
    $display("half store to 101 misalign_err=%b wr_req=%b", misalign_err, d_write_req);
    wait_drain();

    repeat (2) idle_in();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
